// File: rtl/hdmi_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hdmi_audio_pkg
//  Purpose : Shared types and constants for the HDMI audio source scheduler.
//            Holds the scheduler state encoding, the sample-word width
//            helper and the width of the underrun statistics counter.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package hdmi_audio_pkg;

  // Scheduler states: MUTE emits silence, PRIME fills the external FIFO
  // while still silent, RUN forwards the latched source.
  typedef enum logic [1:0] {
    MUTE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

  localparam int UNDERRUN_CNT_W = 16;

  // A stereo sample word is {right, left}.
  function automatic int SAMPLE_W(input int audio_bit_width);
    return 2 * audio_bit_width;
  endfunction

endpackage : hdmi_audio_pkg
`default_nettype wire

// File: rtl/audio_source_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module  : audio_source_scheduler_if
//  Purpose : valid/ready stream carrying external stereo sample words into
//            the audio source scheduler.
//  Ports   : s_valid  word valid         (master -> slave)
//            s_word   stereo word        (master -> slave)
//            s_ready  word accepted      (slave  -> master)
//  Rev     : 1.0  initial release
// ============================================================================
interface audio_source_scheduler_if #(
  parameter int W = 32
);

  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_word;

  modport master (output s_valid, output s_word, input  s_ready);
  modport slave  (input  s_valid, input  s_word, output s_ready);

endinterface : audio_source_scheduler_if
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : audio_sample_fifo
//  Purpose : Synchronous first-word-fall-through FIFO for stereo sample
//            words. o_pop_data always shows the oldest entry; a pop retires
//            it on the clock edge. Flush empties the FIFO and wins over push.
//  Ports   : clk_audio, reset (sync, active-high)
//            i_push/i_push_data  write side (ignored when full)
//            i_pop/o_pop_data    read side (ignored when empty)
//            i_flush             discard all content
//            o_level/o_full/o_empty  occupancy
//  Rev     : 1.0  initial release
// ============================================================================
module audio_sample_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  wire logic                  clk_audio,
  input  wire logic                  reset,
  input  wire logic                  i_push,
  input  wire logic [WIDTH-1:0]      i_push_data,
  input  wire logic                  i_pop,
  output logic      [WIDTH-1:0]      o_pop_data,
  input  wire logic                  i_flush,
  output logic      [DEPTH_LOG2:0]   o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int                  c_depth     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth_lvl = (DEPTH_LOG2 + 1)'(c_depth);

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == c_depth_lvl);
  assign w_empty = (r_level == '0);
  assign w_push  = i_push && !w_full  && !i_flush;
  assign w_pop   = i_pop  && !w_empty && !i_flush;

  // Storage carries no reset; the pointers and level define validity.
  always_ff @(posedge clk_audio) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk_audio) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_level    = r_level;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule : audio_sample_fifo
`default_nettype wire

// File: rtl/audio_source_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : audio_source_scheduler
//  Purpose : Per-sample source selection for the HDMI packet picker. Chooses
//            between a buffered external stereo stream and the internal tone
//            generator, mutes on every source change, primes the external
//            FIFO before use and keeps a saturating underrun count.
//  Ports   : clk_audio, reset     sample clock, sync active-high reset
//            sel_ext              requested source (1 = external)
//            s_if (slave)         external valid/ready word stream
//            tone_word/tone_ack   tone generator word and consume flag
//            audio_sample_word    registered output sample
//            active_ext, muted    latched source, silent-state flag
//            fifo_level           external FIFO occupancy
//            underrun_count       saturating underrun statistics
//  Rev     : 1.0  initial release
// ============================================================================
module audio_source_scheduler
  import hdmi_audio_pkg::*;
#(
  parameter int   AUDIO_BIT_WIDTH = 16,
  parameter int   FIFO_DEPTH_LOG2 = 2,
  parameter int   PREFILL         = 2,
  parameter int   MUTE_SAMPLES    = 8,
  parameter logic UNDERRUN_HOLD   = 1'b1,
  localparam int  SW              = SAMPLE_W(AUDIO_BIT_WIDTH)
) (
  input  wire logic                      clk_audio,
  input  wire logic                      reset,
  input  wire logic                      sel_ext,
  audio_source_scheduler_if.slave        s_if,
  input  wire logic [SW-1:0]             tone_word,
  output logic                           tone_ack,
  output logic      [SW-1:0]             audio_sample_word,
  output logic                           active_ext,
  output logic                           muted,
  output logic      [FIFO_DEPTH_LOG2:0]  fifo_level,
  output logic      [UNDERRUN_CNT_W-1:0] underrun_count
);

  localparam int                       c_mute_w      = (MUTE_SAMPLES > 1) ? $clog2(MUTE_SAMPLES) : 1;
  localparam logic [c_mute_w-1:0]      c_mute_reload = c_mute_w'(MUTE_SAMPLES - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] c_prefill     = (FIFO_DEPTH_LOG2 + 1)'(PREFILL);

  sched_state_t              r_state;
  logic [c_mute_w-1:0]       r_mute_cnt;
  logic                      r_prefill_ok;
  logic                      r_active_ext;
  logic [SW-1:0]             r_sample;
  logic [SW-1:0]             r_last_ext;
  logic                      r_tone_ack;
  logic [UNDERRUN_CNT_W-1:0] r_underrun;

  logic                      w_change;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_flush;
  logic [SW-1:0]             w_fifo_data;
  logic [FIFO_DEPTH_LOG2:0]  w_level;
  logic                      w_full;
  logic                      w_empty;

  // A request that differs from the latched source overrides everything
  // else on the next edge.
  assign w_change = (sel_ext != r_active_ext);

  // The FIFO accepts words only while an external path is being primed or
  // run; a word accepted in a change cycle is dropped by the flush.
  assign s_if.s_ready = r_active_ext && (r_state != MUTE) && !w_full;
  assign w_push       = s_if.s_valid && s_if.s_ready;
  assign w_pop        = (r_state == RUN) && r_active_ext && !w_empty && !w_change;
  assign w_flush      = w_change || (r_state == MUTE);

  audio_sample_fifo #(
    .WIDTH      (SW),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_audio   (clk_audio),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (s_if.s_word),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .i_flush     (w_flush),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      r_state      <= MUTE;
      r_mute_cnt   <= c_mute_reload;
      r_prefill_ok <= 1'b0;
      r_active_ext <= sel_ext;
      r_sample     <= '0;
      r_last_ext   <= '0;
      r_tone_ack   <= 1'b0;
      r_underrun   <= '0;
    end else if (w_change) begin
      r_state      <= MUTE;
      r_mute_cnt   <= c_mute_reload;
      r_prefill_ok <= 1'b0;
      r_active_ext <= sel_ext;
      r_sample     <= '0;
      r_tone_ack   <= 1'b0;
    end else begin
      case (r_state)
        MUTE: begin
          r_sample     <= '0;
          r_tone_ack   <= 1'b0;
          r_prefill_ok <= 1'b0;
          if (r_mute_cnt == '0) begin
            r_state <= r_active_ext ? PRIME : RUN;
          end else begin
            r_mute_cnt <= r_mute_cnt - 1'b1;
          end
        end

        PRIME: begin
          r_sample   <= '0;
          r_tone_ack <= 1'b0;
          // The level check is registered, so RUN follows one edge after
          // the prefill threshold is observed.
          r_prefill_ok <= (w_level >= c_prefill);
          if (r_prefill_ok) begin
            r_state <= RUN;
          end
        end

        RUN: begin
          if (r_active_ext) begin
            r_tone_ack <= 1'b0;
            if (!w_empty) begin
              r_sample   <= w_fifo_data;
              r_last_ext <= w_fifo_data;
            end else begin
              // Underrun: no re-prime, just fill the slot and count it.
              r_sample <= UNDERRUN_HOLD ? r_last_ext : '0;
              if (r_underrun != '1) begin
                r_underrun <= r_underrun + 1'b1;
              end
            end
          end else begin
            r_sample   <= tone_word;
            r_tone_ack <= 1'b1;
          end
        end

        default: begin
          r_state    <= MUTE;
          r_mute_cnt <= c_mute_reload;
          r_sample   <= '0;
          r_tone_ack <= 1'b0;
        end
      endcase
    end
  end

  assign audio_sample_word = r_sample;
  assign tone_ack          = r_tone_ack;
  assign active_ext        = r_active_ext;
  assign muted             = (r_state != RUN);
  assign fifo_level        = w_level;
  assign underrun_count    = r_underrun;

endmodule : audio_source_scheduler
`default_nettype wire

// File: tb/tb_audio_source_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_audio_source_scheduler
//  Purpose : Self-checking bench for audio_source_scheduler. Instance A uses
//            the default parameters (PREFILL 2, hold on underrun); instance B
//            uses PREFILL 4 and zero-fill on underrun. Accepted external
//            words go into a scoreboard queue and are compared in order as
//            they appear on the selected instance's output.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_audio_source_scheduler;

  localparam int SW = 32;

  logic          clk_audio = 1'b0;
  logic          reset     = 1'b1;
  logic          sel_a     = 1'b0;
  logic          sel_b     = 1'b0;
  logic [SW-1:0] tone_word = 32'h1234_5678;
  logic          use_b     = 1'b0;

  always #5 clk_audio = ~clk_audio;

  audio_source_scheduler_if #(.W(SW)) if_a ();
  audio_source_scheduler_if #(.W(SW)) if_b ();

  logic [SW-1:0] out_a, out_b;
  logic          ack_a, ack_b, act_a, act_b, mut_a, mut_b;
  logic [2:0]    lvl_a, lvl_b;
  logic [15:0]   urn_a, urn_b;

  audio_source_scheduler u_dut_a (
    .clk_audio         (clk_audio),
    .reset             (reset),
    .sel_ext           (sel_a),
    .s_if              (if_a),
    .tone_word         (tone_word),
    .tone_ack          (ack_a),
    .audio_sample_word (out_a),
    .active_ext        (act_a),
    .muted             (mut_a),
    .fifo_level        (lvl_a),
    .underrun_count    (urn_a)
  );

  audio_source_scheduler #(
    .PREFILL       (4),
    .UNDERRUN_HOLD (1'b0)
  ) u_dut_b (
    .clk_audio         (clk_audio),
    .reset             (reset),
    .sel_ext           (sel_b),
    .s_if              (if_b),
    .tone_word         (tone_word),
    .tone_ack          (ack_b),
    .audio_sample_word (out_b),
    .active_ext        (act_b),
    .muted             (mut_b),
    .fifo_level        (lvl_b),
    .underrun_count    (urn_b)
  );

  // View of whichever instance the current test exercises.
  logic [SW-1:0] m_out;
  logic          m_muted, m_ready;
  logic [2:0]    m_level;
  logic [15:0]   m_urun;
  assign m_out   = use_b ? out_b : out_a;
  assign m_muted = use_b ? mut_b : mut_a;
  assign m_ready = use_b ? if_b.s_ready : if_a.s_ready;
  assign m_level = use_b ? lvl_b : lvl_a;
  assign m_urun  = use_b ? urn_b : urn_a;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
  endfunction

  logic [31:0] sb_q[$];
  logic [31:0] prev_out;
  logic        prev_muted;
  int          pops, repeats, zeros_run, lead_zeros;
  int          snap_rep, snap_zero, snap_urun;
  logic [31:0] snap_word;
  logic        snap_taken;
  int          max_level, ready_full_viol;

  task automatic clear_monitor();
    sb_q.delete();
    prev_out = '0;      prev_muted = 1'b1;
    pops = 0;           repeats = 0;   zeros_run = 0; lead_zeros = 0;
    snap_rep = 0;       snap_zero = 0; snap_urun = 0;
    snap_word = '0;     snap_taken = 1'b0;
    max_level = 0;      ready_full_viol = 0;
  endtask

  // Called once per negedge: classifies the sample produced by the last edge.
  task automatic monitor();
    logic [31:0] exp_w;
    if (m_out != prev_out && m_out != '0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", m_out, 32'h0);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_word_order", m_out, exp_w);
        pops++;
        if (!snap_taken && exp_w == snap_word) begin
          snap_taken = 1'b1;
          snap_rep   = repeats;
          snap_zero  = zeros_run;
          snap_urun  = int'(m_urun);
        end
      end
    end else if (!prev_muted) begin
      if (m_out == '0) zeros_run++;
      else if (m_out == prev_out) repeats++;
    end
    if (pops == 0 && m_out == '0) lead_zeros++;
    if (int'(m_level) > max_level) max_level = int'(m_level);
    if (m_level == 3'd4 && m_ready) ready_full_viol++;
    prev_out   = m_out;
    prev_muted = m_muted;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    if (use_b) begin if_b.s_valid = v; if_b.s_word = w; end
    else       begin if_a.s_valid = v; if_a.s_word = w; end
  endtask

  // Feed n words; if stall_idx >= 0, after word stall_idx is accepted hold
  // off until it reaches the output, then leave two more edges without a
  // word so the third empty edge overlaps the next push.
  task automatic run_ext(input int n_words, input int stall_idx, input int cycles);
    int   idx = 0;
    int   st  = 0;
    int   gap = 0;
    logic v;
    snap_word  = (stall_idx >= 0) ? wd(stall_idx + 1) : 32'h0;
    snap_taken = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_audio);
      monitor();
      if (st == 0 && stall_idx >= 0 && idx == stall_idx + 1) st = 1;
      if (st == 1 && m_out == wd(stall_idx)) begin st = 2; gap = 2; end
      if (st == 2 && gap == 0) st = 3;
      v = (idx < n_words) && (st == 0 || st == 3);
      if (st == 2) gap--;
      drive(v, wd(idx));
      #1;
      if (v && m_ready) begin
        sb_q.push_back(wd(idx));
        idx++;
      end
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic do_reset(input logic sa, input logic sb);
    @(negedge clk_audio);
    reset = 1'b1; sel_a = sa; sel_b = sb;
    if_a.s_valid = 1'b0; if_a.s_word = '0;
    if_b.s_valid = 1'b0; if_b.s_word = '0;
    @(negedge clk_audio);
    @(negedge clk_audio);
    reset = 1'b0;
    clear_monitor();
  endtask

  task automatic check_reset_a(input logic exp_act);
    check("rst_word",  out_a,         32'h0);
    check("rst_ack",   ack_a,         1'b0);
    check("rst_ready", if_a.s_ready,  1'b0);
    check("rst_muted", mut_a,         1'b1);
    check("rst_level", lvl_a,         3'd0);
    check("rst_urun",  urn_a,         16'h0);
    check("rst_act",   act_a,         exp_act);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    clear_monitor();

    // T1: tone path after reset.
    use_b = 1'b0;
    do_reset(1'b0, 1'b0);
    check_reset_a(1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_audio);
      check("t1_word", out_a, (k <= 8) ? 32'h0 : tone_word);
      check("t1_ack",  ack_a, (k >= 9) ? 1'b1 : 1'b0);
    end

    // T2: external path, eight words in order.
    do_reset(1'b1, 1'b0);
    check_reset_a(1'b1);
    run_ext(8, -1, 40);
    check("t2_pops",      pops,             8);
    check("t2_sb_left",   sb_q.size(),      0);
    check("t2_lead_zero", lead_zeros >= 8,  1'b1);

    // T3: underrun with hold on instance A.
    do_reset(1'b1, 1'b0);
    run_ext(8, 5, 40);
    check("t3_snap",      snap_taken, 1'b1);
    check("t3_hold_rep",  snap_rep,   3);
    check("t3_no_zero",   snap_zero,  0);
    check("t3_urun",      snap_urun,  3);
    check("t3_pops",      pops,       8);

    // T3b/T4: zero-fill underrun and fill-to-full priming on instance B.
    use_b = 1'b1;
    do_reset(1'b0, 1'b1);
    run_ext(8, 5, 40);
    check("t3b_snap",     snap_taken,      1'b1);
    check("t3b_zeros",    snap_zero,       3);
    check("t3b_no_rep",   snap_rep,        0);
    check("t3b_urun",     snap_urun,       3);
    check("t3b_pops",     pops,            8);
    check("t4_max_level", max_level,       4);
    check("t4_full_rdy",  ready_full_viol, 0);

    // T5: source toggles 1->0->1, three cycles apart.
    use_b = 1'b0;
    do_reset(1'b1, 1'b0);
    run_ext(8, -1, 20);
    check("t5_run", mut_a, 1'b0);
    @(negedge clk_audio);
    sel_a = 1'b0;
    @(negedge clk_audio);
    check("t5_t1_muted", mut_a, 1'b1);
    check("t5_t1_level", lvl_a, 3'd0);
    check("t5_t1_act",   act_a, 1'b0);
    check("t5_t1_word",  out_a, 32'h0);
    @(negedge clk_audio);
    @(negedge clk_audio);
    sel_a = 1'b1;
    if_a.s_valid = 1'b1; if_a.s_word = wd(40);
    @(negedge clk_audio);
    check("t5_t2_muted", mut_a, 1'b1);
    check("t5_t2_act",   act_a, 1'b1);
    check("t5_t2_level", lvl_a, 3'd0);
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_audio);
      if (lvl_a == 3'd0 && out_a == 32'h0) cnt++;
    end
    check("t5_mute_zeros", cnt, 8);
    @(negedge clk_audio);
    check("t5_prime_fill",  lvl_a, 3'd1);
    check("t5_prime_muted", mut_a, 1'b1);
    if_a.s_valid = 1'b0;

    // T6: counter saturation, then reset in mid-RUN with a pending change.
    do_reset(1'b1, 1'b0);
    run_ext(2, -1, 20);
    for (int k = 0; k < 65600; k++) @(negedge clk_audio);
    check("t6_sat",   urn_a, 16'hFFFF);
    check("t6_run",   mut_a, 1'b0);
    check("t6_hold",  out_a, wd(1));
    reset = 1'b1;
    sel_a = 1'b0;
    @(negedge clk_audio);
    check_reset_a(1'b0);
    reset = 1'b0;
    @(negedge clk_audio);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_audio_source_scheduler
`default_nettype wire
